// File: rtl/fetch_pkg.sv
// Shared state encoding and constants for the instruction fetch unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  localparam int                      INSTR_WIDTH      = 32;
  localparam logic [INSTR_WIDTH-1:0]  NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0]             RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry {pc, instr} buffer between instruction memory and decode.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [ADDRESS_WIDTH-1:0] push_pc,
  input  logic [INSTR_WIDTH-1:0]   push_instr,
  output logic [1:0]               count,
  output logic [ADDRESS_WIDTH-1:0] head_pc,
  output logic [INSTR_WIDTH-1:0]   head_instr
);

  logic [1:0][ADDRESS_WIDTH-1:0] pc_mem;
  logic [1:0][INSTR_WIDTH-1:0]   instr_mem;
  logic                          wr_ptr, rd_ptr;
  logic                          do_push, do_pop;

  // Guard against over/underflow even if the caller misbehaves.
  assign do_pop  = pop & (count != 2'd0);
  assign do_push = push & ((count != 2'd2) | do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_mem    <= {2{RESET_PC}};
      instr_mem <= {2{NOP_INSTR}};
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        pc_mem[wr_ptr]    <= push_pc;
        instr_mem[wr_ptr] <= push_instr;
        wr_ptr            <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign head_pc    = pc_mem[rd_ptr];
  assign head_instr = instr_mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: single-outstanding memory requests, 2-entry buffer, branch redirect.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = ADDRESS_WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  input  logic                     imem_ack,
  input  logic [INSTR_WIDTH-1:0]   imem_rdata,
  output logic [INSTR_WIDTH-1:0]   instr,
  output logic [ADDRESS_WIDTH-1:0] pc_out,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  input  logic                     PCsrc,
  input  logic [ADDRESS_WIDTH-1:0] ImmOp
);

  fetch_state_t             state, state_next;
  logic [ADDRESS_WIDTH-1:0] fetch_pc, redirect_pc, branch_sum, target;
  logic [1:0]               count, count_after;
  logic                     outstanding, outstanding_after;
  logic                     ack, accept, redirect, push, pop, issue_ok, req_next;

  assign ack        = outstanding & imem_ack;
  assign accept     = instr_valid & instr_ready;
  assign redirect   = accept & PCsrc;
  assign pop        = accept & ~redirect;
  assign branch_sum = pc_out + ImmOp;
  assign target     = branch_sum & {{(ADDRESS_WIDTH-2){1'b1}}, 2'b00};

  // FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    state_next = FETCH;
      FETCH:   if (redirect && outstanding && !ack) state_next = DRAIN;
      DRAIN:   if (ack) state_next = FETCH;
      default: state_next = IDLE;
    endcase
  end

  // FSM: outputs. A DRAIN ack is the stale fetch, so it frees the port but never pushes.
  always_comb begin
    push     = 1'b0;
    issue_ok = 1'b0;
    case (state)
      IDLE:  issue_ok = 1'b1;
      FETCH: begin
        push     = ack & ~redirect;
        issue_ok = ~(redirect & outstanding & ~ack);
      end
      DRAIN: issue_ok = ack;
      default: ;
    endcase
  end

  // Issue decision looks at post-edge occupancy so an ack can chain straight into the next request.
  assign count_after       = redirect ? 2'd0 : (count + {1'b0, push} - {1'b0, pop});
  assign outstanding_after = outstanding & ~ack;
  assign req_next          = outstanding_after | (issue_ok & (count_after < 2'd2));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outstanding <= 1'b0;
      fetch_pc    <= RESET_PC;
      redirect_pc <= RESET_PC;
    end else begin
      outstanding <= req_next;
      if (state == DRAIN) begin
        if (ack) fetch_pc <= redirect_pc;
      end else if (redirect) begin
        if (!outstanding || ack) fetch_pc    <= target;
        else                     redirect_pc <= target;
      end else if (push) begin
        fetch_pc <= fetch_pc + ADDRESS_WIDTH'(4);
      end
    end
  end

  assign imem_req    = outstanding;
  assign imem_addr   = fetch_pc;
  assign instr_valid = (count != 2'd0) && (state != DRAIN);

  fetch_fifo #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .RESET_PC     (RESET_PC)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .flush     (redirect),
    .push_pc   (fetch_pc),
    .push_instr(imem_rdata),
    .count     (count),
    .head_pc   (pc_out),
    .head_instr(instr)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: expected accepts and ack addresses queued, checked by a monitor.
module tb_fetch_unit;

  logic        clk = 1'b0, rst = 1'b0;
  logic        imem_req, instr_valid;
  logic        imem_ack = 1'b0, instr_ready = 1'b0, PCsrc = 1'b0;
  logic [31:0] imem_addr, instr, pc_out;
  logic [31:0] imem_rdata = '0, ImmOp = '0;

  int          n_cmp = 0, n_bad = 0;
  int          lat = 0;
  bit          stray = 1'b0, lat_chk = 1'b0;
  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_addr_q[$];

  fetch_unit u_dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .pc_out     (pc_out),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .PCsrc      (PCsrc),
    .ImmOp      (ImmOp)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hA500_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'd0, act}, {31'd0, exp});
  endtask

  // Memory model: ack after `lat` wait cycles; optional stray acks while no request.
  initial begin : mem
    int wcnt;
    wcnt = 0;
    forever begin
      @(posedge clk); #1;
      imem_ack = 1'b0;
      if (rst && imem_req) begin
        if (wcnt >= lat) begin
          imem_ack   = 1'b1;
          imem_rdata = memf(imem_addr);
          wcnt       = 0;
        end else wcnt++;
      end else begin
        wcnt = 0;
        if (stray) begin
          imem_ack   = 1'b1;
          imem_rdata = 32'hDEAD_BEEF;
        end
      end
    end
  end

  // Monitor: request hold, ack addresses, accepted {pc, instr}, ack-to-valid latency.
  initial begin : mon
    logic [31:0] e, prev_addr;
    bit          prev_wait, prev_ack;
    prev_wait = 1'b0; prev_ack = 1'b0; prev_addr = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_wait = 1'b0;
        prev_ack  = 1'b0;
      end else begin
        if (prev_wait) begin
          chk1("req_hold", imem_req, 1'b1);
          chk("addr_hold", imem_addr, prev_addr);
        end
        if (lat_chk && prev_ack) chk1("valid_after_ack", instr_valid, 1'b1);
        if (imem_req && imem_ack && exp_addr_q.size() != 0) begin
          e = exp_addr_q.pop_front();
          chk("fetch_addr", imem_addr, e);
        end
        if (instr_valid && instr_ready) begin
          if (exp_pc_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_accept: got pc %h, want no accept", pc_out);
          end else begin
            e = exp_pc_q.pop_front();
            chk("pc_out", pc_out, e);
            chk("instr", instr, memf(e));
          end
        end
        prev_wait = imem_req && !imem_ack;
        prev_ack  = imem_req && imem_ack;
        prev_addr = imem_addr;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; instr_ready = 1'b0; PCsrc = 1'b0; ImmOp = '0;
    stray = 1'b0; lat_chk = 1'b0;
    exp_pc_q.delete(); exp_addr_q.delete();
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_req", imem_req, 1'b0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_pc", pc_out, 32'h0);
    chk1("rst_valid", instr_valid, 1'b0);
    rst = 1'b1;
  endtask

  task automatic exp_pc(input logic [31:0] p);   exp_pc_q.push_back(p);   endtask
  task automatic exp_addr(input logic [31:0] a); exp_addr_q.push_back(a); endtask

  task automatic wait_pc(input logic [31:0] p);
    bit hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      step();
      hit = instr_valid && (pc_out == p);
    end
    chk1("reach_pc", hit, 1'b1);
  endtask

  task automatic wait_drain();
    bit done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      step();
      done = (exp_pc_q.size() == 0) && (exp_addr_q.size() == 0);
    end
    instr_ready = 1'b0;
    chk1("drain", done, 1'b1);
  endtask

  initial begin
    // Zero-wait streaming, then 10 cycles of backpressure with stray acks
    do_reset(); lat = 0; instr_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin exp_pc(32'(i*4)); exp_addr(32'(i*4)); end
    wait_pc(32'h1C);
    instr_ready = 1'b0; stray = 1'b1;
    repeat (10) step();
    stray = 1'b0;
    chk1("sat_req", imem_req, 1'b0);
    chk("sat_count", {30'd0, u_dut.count}, 32'd2);
    chk("sat_head", pc_out, 32'h1C);
    instr_ready = 1'b1;
    wait_drain();

    // 3-wait memory: address held, valid one cycle after each ack
    do_reset(); lat = 3; instr_ready = 1'b1; lat_chk = 1'b1;
    for (int i = 0; i < 4; i++) begin exp_pc(32'(i*4)); exp_addr(32'(i*4)); end
    wait_drain(); lat_chk = 1'b0;

    // Redirect from 0x10 by -8 with nothing outstanding
    do_reset(); lat = 0; instr_ready = 1'b1;
    exp_pc(32'h0); exp_pc(32'h4); exp_pc(32'h8); exp_pc(32'hC); exp_pc(32'h10);
    exp_pc(32'h8); exp_pc(32'hC); exp_pc(32'h10); exp_pc(32'h14);
    for (int i = 0; i < 6; i++) exp_addr(32'(i*4));
    exp_addr(32'h8); exp_addr(32'hC); exp_addr(32'h10); exp_addr(32'h14);
    wait_pc(32'h10);
    instr_ready = 1'b0;
    repeat (5) step();
    chk1("d_no_outstanding", imem_req, 1'b0);
    instr_ready = 1'b1; PCsrc = 1'b1; ImmOp = 32'hFFFF_FFF8;
    step(); PCsrc = 1'b0; ImmOp = '0;
    chk("d_next_addr", imem_addr, 32'h8);
    chk1("d_req", imem_req, 1'b1);
    chk1("d_flushed", instr_valid, 1'b0);
    wait_drain();

    // Redirect from 0x20 by +0x40 while the next fetch is in flight: DRAIN drops it
    do_reset(); lat = 3; instr_ready = 1'b1;
    for (int i = 0; i < 9; i++)  exp_pc(32'(i*4));
    exp_pc(32'h60); exp_pc(32'h64);
    for (int i = 0; i < 10; i++) exp_addr(32'(i*4));
    exp_addr(32'h60); exp_addr(32'h64);
    wait_pc(32'h20);
    chk1("e_outstanding", imem_req, 1'b1);
    PCsrc = 1'b1; ImmOp = 32'h40;
    step(); PCsrc = 1'b0; ImmOp = '0;
    chk1("e_drain_valid", instr_valid, 1'b0);
    chk1("e_drain_req", imem_req, 1'b1);
    chk("e_drain_addr", imem_addr, 32'h24);
    begin
      bit moved = 1'b0;
      for (int i = 0; i < 20 && !moved; i++) begin step(); moved = (imem_addr != 32'h24); end
    end
    chk("e_next_addr", imem_addr, 32'h60);
    wait_drain();

    // Redirect in the same cycle as an ack; target low bits cleared
    do_reset(); lat = 0; instr_ready = 1'b1;
    exp_pc(32'h0); exp_pc(32'h4); exp_pc(32'h8); exp_pc(32'h108); exp_pc(32'h10C);
    exp_addr(32'h0); exp_addr(32'h4); exp_addr(32'h8); exp_addr(32'hC);
    exp_addr(32'h108); exp_addr(32'h10C);
    wait_pc(32'h8);
    PCsrc = 1'b1; ImmOp = 32'h102;
    step(); PCsrc = 1'b0; ImmOp = '0;
    chk("f_next_addr", imem_addr, 32'h108);
    chk1("f_req", imem_req, 1'b1);
    chk1("f_flushed", instr_valid, 1'b0);
    wait_drain();

    // Address wrap: branch to 0xFFFF_FFFC, next sequential fetch is 0x0
    do_reset(); lat = 0; instr_ready = 1'b1;
    exp_pc(32'h0); exp_pc(32'hFFFF_FFFC); exp_pc(32'h0); exp_pc(32'h4);
    exp_addr(32'h0); exp_addr(32'h4); exp_addr(32'hFFFF_FFFC); exp_addr(32'h0); exp_addr(32'h4);
    wait_pc(32'h0);
    PCsrc = 1'b1; ImmOp = 32'hFFFF_FFFC;
    step(); PCsrc = 1'b0; ImmOp = '0;
    chk("h_wrap_addr", imem_addr, 32'hFFFF_FFFC);
    wait_drain();

    // Reset mid-wait, then minimum reset-to-valid latency
    do_reset(); lat = 4; instr_ready = 1'b1;
    exp_pc(32'h0); exp_pc(32'h4); exp_addr(32'h0); exp_addr(32'h4);
    wait_pc(32'h4);
    step();
    chk1("g_wait_req", imem_req, 1'b1);
    chk("g_wait_addr", imem_addr, 32'h8);
    #2 rst = 1'b0;
    #1;
    chk1("g_async_req", imem_req, 1'b0);
    chk("g_async_addr", imem_addr, 32'h0);
    chk1("g_async_valid", instr_valid, 1'b0);
    do_reset(); lat = 0; instr_ready = 1'b1;
    exp_pc(32'h0); exp_pc(32'h4); exp_addr(32'h0); exp_addr(32'h4);
    step();
    chk1("g_lat1_valid", instr_valid, 1'b0);
    chk1("g_lat1_req", imem_req, 1'b1);
    step();
    chk1("g_lat2_valid", instr_valid, 1'b1);
    chk("g_lat2_pc", pc_out, 32'h0);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
